// File: rtl/interboard_output_if.sv
// interboard_output_if: FIFO-side and link-side signals of the inter-board transmit stage
interface interboard_output_if #(parameter int WIDTH = 11);
  logic rdempty;
  logic [WIDTH-1:0] q;
  logic rdreq;
  logic read;
  logic [WIDTH-1:0] send_data;
  logic valid;
  modport master(input rdempty, q, read, output rdreq, send_data, valid);
  modport slave(output rdempty, q, read, input rdreq, send_data, valid);
endinterface

// File: rtl/interboard_output.sv
// interboard_output: drains the outbound FIFO onto the inter-board link under remote read flow control,
// with a wrapping word counter and a sticky stall watchdog.
module interboard_output #(
  parameter int WIDTH = 11,
  parameter logic [15:0] STALL_LIMIT = 16'd1024,
  parameter int CNT_W = 16
) (
  input logic transmit_clk,
  input logic reset,
  interboard_output_if.master link,
  input logic clear_stats,
  output logic [CNT_W-1:0] words_sent,
  output logic stall_timeout
);
  typedef enum logic [1:0] {IDLE, STREAM, BLOCKED} state_t;
  state_t state, state_nx;
  logic read_q, rd_pend, rdreq, valid_r;
  logic [WIDTH-1:0] data_r;
  logic [15:0] stall_cnt;
  assign rdreq = state == STREAM && read_q && !link.rdempty;
  assign link.rdreq = rdreq;
  assign link.valid = valid_r;
  assign link.send_data = data_r;
  // STREAM and BLOCKED share exits; IDLE only leaves once the FIFO has data
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && link.rdempty) ? IDLE :
               !read_q ? BLOCKED :
               link.rdempty ? IDLE : STREAM;
  end
  always_ff @(posedge transmit_clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge transmit_clk or posedge reset)
    if (reset) begin
      read_q <= 1'b0;
      rd_pend <= 1'b0;
      valid_r <= 1'b0;
      data_r <= '0;
    end else begin
      read_q <= link.read;
      rd_pend <= rdreq;
      valid_r <= rd_pend;
      data_r <= rd_pend ? link.q : data_r;
    end
  always_ff @(posedge transmit_clk or posedge reset)
    if (reset) begin
      words_sent <= '0;
      stall_cnt <= '0;
      stall_timeout <= 1'b0;
    end else if (clear_stats) begin
      words_sent <= '0;
      stall_cnt <= '0;
      stall_timeout <= 1'b0;
    end else begin
      words_sent <= valid_r ? words_sent + CNT_W'(1) : words_sent;
      stall_cnt <= state != BLOCKED ? '0 :
                   (link.rdempty || stall_cnt == STALL_LIMIT) ? stall_cnt : stall_cnt + 16'd1;
      stall_timeout <= stall_timeout |
                       (state == BLOCKED && !link.rdempty && stall_cnt == STALL_LIMIT - 16'd1);
    end
endmodule

// File: tb/tb_interboard_output.sv
// tb_interboard_output: scoreboard bench; a FIFO model feeds the DUT and a monitor checks every sent word.
module tb_interboard_output;
  localparam int WIDTH = 11;
  localparam int CNT_W = 4;
  logic transmit_clk = 1'b0;
  logic reset = 1'b1;
  logic clear_stats = 1'b0;
  logic [CNT_W-1:0] words_sent;
  logic stall_timeout;
  int checks = 0;
  int errors = 0;
  int sent = 0;
  int wr_ptr = 0;
  int rd_ptr = 0;
  int next_id = 0;
  logic [WIDTH-1:0] mem [0:1023];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] mon_exp;
  interboard_output_if #(.WIDTH(WIDTH)) link();
  interboard_output #(.WIDTH(WIDTH), .STALL_LIMIT(16'd8), .CNT_W(CNT_W)) dut (
    .transmit_clk(transmit_clk),
    .reset(reset),
    .link(link),
    .clear_stats(clear_stats),
    .words_sent(words_sent),
    .stall_timeout(stall_timeout)
  );
  always #5 transmit_clk = ~transmit_clk;
  assign link.rdempty = (wr_ptr == rd_ptr);
  always @(posedge transmit_clk)
    if (link.rdreq) begin
      link.q <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  always @(negedge transmit_clk) begin
    if (link.valid) begin
      sent++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %0d expected none", link.send_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (link.send_data !== mon_exp) begin
          errors++;
          $display("FAIL word_order: got %0d expected %0d", link.send_data, mon_exp);
        end
      end
    end
    if (link.rdreq) begin
      checks++;
      if (link.rdempty) begin
        errors++;
        $display("FAIL rdreq_when_empty: got rdreq=1 expected 0");
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic tick();
    @(negedge transmit_clk);
  endtask
  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load(int n);
    logic [WIDTH-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = WIDTH'(next_id * 97 + 13);
      mem[wr_ptr % 1024] = v;
      wr_ptr++;
      exp_q.push_back(v);
      next_id++;
    end
  endtask
  task automatic clr();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
  endtask
  task automatic drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (2) tick();
  endtask
  initial begin
    logic [9:0] rq_h, vd_h;
    int extra, rq_cnt, vd_cnt, n, base;
    link.read = 1'b1;
    load(5);
    repeat (3) tick();
    check("reset_valid", link.valid, 0);
    check("reset_rdreq", link.rdreq, 0);
    check("reset_send_data", link.send_data, 0);
    check("reset_words_sent", words_sent, 0);
    check("reset_stall_timeout", stall_timeout, 0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      rq_h[k] = link.rdreq;
      vd_h[k] = link.valid;
    end
    check("t1_rdreq_cycles", rq_h, 10'h03E);
    check("t1_valid_cycles", vd_h, 10'h0F8);
    check("t1_words_sent", words_sent, 5);
    check("t1_drained", exp_q.size(), 0);
    clr();
    base = sent;
    load(100);
    n = 0;
    while (sent - base < 40 && n < 500) begin
      tick();
      n++;
    end
    check("t2_reach_word40", sent - base, 40);
    link.read = 1'b0;
    extra = 0;
    rq_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      extra += int'(link.valid);
      rq_cnt += int'(link.rdreq);
    end
    link.read = 1'b1;
    check("t2_extra_valid_le4", int'(extra <= 4), 1);
    check("t2_rdreq_while_blocked", rq_cnt, 0);
    drain("t2_drained");
    check("t2_words_delivered", sent - base, 100);
    check("t2_words_sent_wrapped", words_sent, 4);
    clr();
    link.read = 1'b0;
    repeat (4) tick();
    load(3);
    rq_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      rq_cnt += int'(link.rdreq);
      if (c == 8) check("t3_before_limit", stall_timeout, 0);
      if (c == 9) check("t3_at_limit", stall_timeout, 1);
    end
    check("t3_still_set", stall_timeout, 1);
    check("t3_no_rdreq", rq_cnt, 0);
    link.read = 1'b1;
    drain("t3_drained");
    check("t3_sticky_after_read", stall_timeout, 1);
    clr();
    check("t3_cleared", stall_timeout, 0);
    check("t3_words_cleared", words_sent, 0);
    rq_cnt = 0;
    vd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      link.read = (i % 3 == 0) ? 1'b1 : ~link.read;
      tick();
      rq_cnt += int'(link.rdreq);
      vd_cnt += int'(link.valid);
    end
    link.read = 1'b1;
    check("t4_no_rdreq", rq_cnt, 0);
    check("t4_no_valid", vd_cnt, 0);
    check("t4_no_stall", stall_timeout, 0);
    clr();
    load(17);
    drain("t5_drained");
    check("t5_words_sent_17", words_sent, 1);
    load(1);
    n = 0;
    while (!link.valid && n < 20) begin
      tick();
      n++;
    end
    check("t5_valid_seen", link.valid, 1);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("t5_clear_wins", words_sent, 0);
    repeat (3) tick();
    check("t5_clear_holds", words_sent, 0);
    repeat (4) tick();
    base = sent;
    load(6);
    repeat (3) tick();
    check("t6_inflight_valid", link.valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", link.valid, 0);
    check("t6_async_rdreq", link.rdreq, 0);
    void'(exp_q.pop_front());
    repeat (2) tick();
    reset = 1'b0;
    drain("t6_drained");
    check("t6_words_delivered", sent - base, 5);
    check("t6_words_sent", words_sent, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
